// File: rtl/two_byte_serial_right_shifter.sv
// rtl/two_byte_serial_right_shifter.sv - iterative 16-bit right shifter (logical/arithmetic/rotate), one bit per clock
module two_byte_serial_right_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode;
  logic             carry;
  logic             valid_r;
  logic             fill_bit;

  // Bit entering at the MSB on each step; reserved mode 11 falls through to logical fill.
  always_comb begin
    fill_bit = 1'b0;
    case (mode)
      MODE_ARITH:  fill_bit = sreg[WIDTH-1];
      MODE_ROTATE: fill_bit = sreg[0];
      default:     fill_bit = 1'b0;
    endcase
  end

  // Control FSM plus the shift datapath; the result registers double as the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      mode    <= '0;
      carry   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= in_data;
            mode  <= in_mode;
            cnt   <= in_amount;
            carry <= 1'b0;
            if (in_amount != '0) begin
              state <= SHIFT;
            end else begin
              state   <= DONE;
              valid_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sreg  <= {fill_bit, sreg[WIDTH-1:1]};
          carry <= sreg[0];
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
          // Counter at 1 means this edge performs the final step.
          if (cnt <= 1) begin
            state   <= DONE;
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = valid_r;
  assign out_data  = sreg;
  assign out_carry = carry;
  assign out_zero  = (sreg == '0);

endmodule
